// File: rtl/multi_edge_detect.sv
// rtl/multi_edge_detect.sv - per-channel synchronised, glitch-filtered edge detector
// Events feed sticky flags, an interrupt and a saturating event counter.
module multi_edge_detect #(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                    i_clk,
   input  logic                    rst_n,
   input  logic [CHANNELS-1:0]     level,
   input  logic [2*CHANNELS-1:0]   mode,
   input  logic [CHANNELS-1:0]     clr,
   input  logic                    cnt_clr,
   output logic [CHANNELS-1:0]     filt_level,
   output logic [CHANNELS-1:0]     toggle,
   output logic [CHANNELS-1:0]     sticky,
   output logic [CNT_WIDTH-1:0]    evt_cnt,
   output logic                    irq
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int SW = CNT_WIDTH + 1;

   logic [CHANNELS-1:0] sync_q   [SYNC_STAGES];
   logic [FW-1:0]       filt_cnt [CHANNELS];

   logic [FW-1:0]       cnt_n    [CHANNELS];
   logic [CHANNELS-1:0] filt_n;
   logic [CHANNELS-1:0] tog_n;
   logic [CHANNELS-1:0] sticky_n;
   logic [SW-1:0]       sum;
   logic [CNT_WIDTH-1:0] evt_n;
   logic                s_bit;

   always_comb begin
      filt_n = filt_level;
      tog_n  = '0;
      s_bit  = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         s_bit    = sync_q[SYNC_STAGES-1][i];
         cnt_n[i] = '0;
         if (s_bit != filt_level[i]) begin
            if (filt_cnt[i] == FW'(FILTER_LEN - 1)) begin
               filt_n[i] = s_bit;
               // mode is sampled only at the moment the new level is accepted
               case (mode[2*i +: 2])
                  2'b00:   tog_n[i] = s_bit;
                  2'b01:   tog_n[i] = ~s_bit;
                  2'b10:   tog_n[i] = 1'b1;
                  default: tog_n[i] = 1'b0;
               endcase
            end else begin
               cnt_n[i] = filt_cnt[i] + 1'b1;
            end
         end
      end

      sticky_n = (sticky & ~clr) | tog_n;

      sum = cnt_clr ? '0 : {1'b0, evt_cnt};
      for (int i = 0; i < CHANNELS; i++) begin
         sum = sum + SW'(tog_n[i]);
      end
      // CNT_WIDTH >= clog2(CHANNELS+1) keeps the sum below 2^(CNT_WIDTH+1)
      evt_n = sum[SW-1] ? '1 : sum[CNT_WIDTH-1:0];
   end

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
         for (int i = 0; i < CHANNELS; i++) begin
            filt_cnt[i] <= '0;
         end
         filt_level <= '0;
         toggle     <= '0;
         sticky     <= '0;
         evt_cnt    <= '0;
         irq        <= 1'b0;
      end else begin
         sync_q[0] <= level;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         for (int i = 0; i < CHANNELS; i++) begin
            filt_cnt[i] <= cnt_n[i];
         end
         filt_level <= filt_n;
         toggle     <= tog_n;
         sticky     <= sticky_n;
         evt_cnt    <= evt_n;
         irq        <= |sticky_n;
      end
   end

endmodule

// File: tb/tb_multi_edge_detect.sv
// tb/tb_multi_edge_detect.sv - randomized scoreboard bench for multi_edge_detect
module tb_multi_edge_detect;

   localparam int CH    = 4;
   localparam int SYNC  = 2;
   localparam int FILT  = 3;
   localparam int CW    = 3;
   localparam int DEPTH = SYNC + FILT;
   localparam int CMAX  = (1 << CW) - 1;

   logic              i_clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [CH-1:0]     level = '0;
   logic [2*CH-1:0]   mode = '0;
   logic [CH-1:0]     clr = '0;
   logic              cnt_clr = 1'b0;
   logic [CH-1:0]     filt_level;
   logic [CH-1:0]     toggle;
   logic [CH-1:0]     sticky;
   logic [CW-1:0]     evt_cnt;
   logic              irq;

   multi_edge_detect #(
      .CHANNELS(CH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .CNT_WIDTH(CW)
   ) dut (
      .i_clk(i_clk), .rst_n(rst_n), .level(level), .mode(mode), .clr(clr),
      .cnt_clr(cnt_clr), .filt_level(filt_level), .toggle(toggle),
      .sticky(sticky), .evt_cnt(evt_cnt), .irq(irq)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [CH-1:0] filt;
      logic [CH-1:0] tog;
      logic [CH-1:0] stk;
      int            cnt;
      logic          irq;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // model state: level history per edge, newest at index 0
   logic          hist [CH][DEPTH];
   logic [CH-1:0] m_filt;
   logic [CH-1:0] m_stk;
   int            m_cnt;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++)
         for (int j = 0; j < DEPTH; j++) hist[c][j] = 1'b0;
      m_filt = '0;
      m_stk  = '0;
      m_cnt  = 0;
   endtask

   // A channel accepts value v once the synchronised input has shown v for
   // FILT consecutive edges while the accepted level was still !v.
   task automatic model_edge();
      exp_t          e;
      logic [CH-1:0] tog;
      logic          all_same;
      logic          v;
      int            base;
      tog = '0;
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int c = 0; c < CH; c++) begin
            for (int j = DEPTH - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = level[c];
            v = hist[c][SYNC];
            all_same = 1'b1;
            for (int j = SYNC; j < DEPTH; j++)
               if (hist[c][j] != v) all_same = 1'b0;
            if (all_same && v != m_filt[c]) begin
               m_filt[c] = v;
               case (mode[2*c +: 2])
                  2'b00: tog[c] = v;
                  2'b01: tog[c] = !v;
                  2'b10: tog[c] = 1'b1;
                  default: tog[c] = 1'b0;
               endcase
            end
         end
         m_stk = (m_stk & ~clr) | tog;
         base  = (cnt_clr ? 0 : m_cnt) + $countones(tog);
         m_cnt = (base > CMAX) ? CMAX : base;
      end
      e.filt = m_filt;
      e.tog  = tog;
      e.stk  = m_stk;
      e.cnt  = m_cnt;
      e.irq  = |m_stk;
      exp_q.push_back(e);
   endtask

   // monitor: every clock edge is an output beat
   initial begin
      exp_t e;
      forever begin
         @(posedge i_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("filt_level", int'(filt_level), int'(e.filt));
            check("toggle", int'(toggle), int'(e.tog));
            check("sticky", int'(sticky), int'(e.stk));
            check("evt_cnt", int'(evt_cnt), e.cnt);
            check("irq", int'(irq), int'(e.irq));
         end
      end
   end

   task automatic step();
      model_edge();
      @(negedge i_clk);
   endtask

   initial begin
      int rst_hold;
      model_reset();
      #2;
      check("reset_filt", int'(filt_level), 0);
      check("reset_toggle", int'(toggle), 0);
      check("reset_sticky", int'(sticky), 0);
      check("reset_cnt", int'(evt_cnt), 0);
      check("reset_irq", int'(irq), 0);
      @(negedge i_clk);
      step();
      rst_n = 1'b1;

      // directed: all channels rise together, cnt_clr on the pulse cycle
      level = '1;
      for (int k = 0; k < SYNC + FILT - 1; k++) step();
      cnt_clr = 1'b1;
      clr = 4'b0001;
      step();
      cnt_clr = 1'b0;
      step();
      clr = '0;
      for (int k = 0; k < 4; k++) step();

      // directed: short glitch on channel 1 then a mid-filter reset
      level = 4'b0000;
      for (int k = 0; k < 8; k++) step();
      level[1] = 1'b1;
      step(); step();
      level[1] = 1'b0;
      for (int k = 0; k < 6; k++) step();
      level = '1;
      step(); step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) step();

      rst_hold = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(4, 0) == 0) level[c] = ~level[c];
         if ($urandom_range(40, 0) == 0) mode = CH'(0) | (2*CH)'($urandom);
         clr     = ($urandom_range(7, 0) == 0) ? CH'($urandom) : '0;
         cnt_clr = ($urandom_range(15, 0) == 0);
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst_n = 1'b1;
         end else if ($urandom_range(499, 0) == 0) begin
            rst_n    = 1'b0;
            rst_hold = $urandom_range(3, 1);
         end
         step();
      end
      rst_n = 1'b1;

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge i_clk);
      check("drain_queue", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_edge_detect.md
MULTI_EDGE_DETECT -- requirements
Module: multi_edge_detect

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent input channels (legal 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per channel (legal >=2).
REQ-003 SHALL have parameter FILTER_LEN, default 3, consecutive cycles a new synchronised level must persist before acceptance (legal >=1).
REQ-004 SHALL have parameter CNT_WIDTH, default 8, event counter width (legal >= clog2(CHANNELS+1)).
REQ-005 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port level  input  CHANNELS  asynchronous raw levels, one bit per channel.
REQ-008 SHALL have port mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 rising, 01 falling, 10 both, 11 disabled.
REQ-009 SHALL have port clr  input  CHANNELS  per-channel sticky-flag clear, level-sampled each cycle.
REQ-010 SHALL have port cnt_clr  input  1  event counter clear, level-sampled each cycle.
REQ-011 SHALL have port filt_level  output  CHANNELS  registered filtered level per channel.
REQ-012 SHALL have port toggle  output  CHANNELS  registered one-cycle edge pulse per channel.
REQ-013 SHALL have port sticky  output  CHANNELS  registered latched event flags.
REQ-014 SHALL have port evt_cnt  output  CNT_WIDTH  registered saturating total event count.
REQ-015 SHALL have port irq  output  1  registered OR of sticky.

Function
REQ-016 Each channel SHALL pass level through a SYNC_STAGES flop chain; sync output = last stage.
REQ-017 Per-channel filter counter: sync == filt_level -> counter <= 0; sync != filt_level and counter == FILTER_LEN-1 -> filt_level <= sync, counter <= 0; otherwise counter increments.
REQ-018 A sync-output excursion shorter than FILTER_LEN cycles SHALL leave filt_level unchanged and return the counter to 0.
REQ-019 Latency: level stable from before edge E1 -> filt_level updates on edge E(SYNC_STAGES+FILTER_LEN); default 5 edges.
REQ-020 Filter and filt_level SHALL track in every mode, including 11; mode only gates event generation.
REQ-021 toggle[i] SHALL be 1 for exactly the cycle following a filt_level[i] update whose direction matches mode (01 rising for 00, 10 falling for 01, either for 10, never for 11); 0 otherwise.
REQ-022 mode changes SHALL take effect on the next filt_level update; no retroactive pulse.
REQ-023 sticky[i] SHALL set on the edge toggle[i] is driven high; clr[i] high clears it; simultaneous set and clr -> sticky[i] = 1 (event not lost).
REQ-024 irq SHALL be registered OR of next-state sticky, i.e. same cycle as sticky.
REQ-025 evt_cnt SHALL add popcount of toggle bits asserted in the same cycle, saturating at 2^CNT_WIDTH-1, no wrap.
REQ-026 cnt_clr with simultaneous events -> evt_cnt <= popcount of that cycle's events (saturated); cnt_clr alone -> 0.

Reset
REQ-027 rst_n low SHALL asynchronously clear sync chains, filter counters, filt_level, toggle, sticky, evt_cnt, irq to 0.
REQ-028 After release, channel with level held 1 SHALL be treated as a rising edge (filt_level starts 0), reported after REQ-019 latency.
REQ-029 Reset asserted mid-filter SHALL discard partial counts; no pulse from pre-reset history.

Verification
REQ-030 Ch0 mode 00, level 0->1 held -> filt_level[0]=1 and toggle[0]=1 pulse 5 edges later, sticky[0]=1, irq=1, evt_cnt=1.
REQ-031 Ch1 mode 00, 2-cycle high glitch (FILTER_LEN=3) -> no toggle, filt_level[1] stays 0, evt_cnt unchanged.
REQ-032 Ch2 mode 10, level 0->1 then 1->0 10 cycles apart -> two single-cycle toggles, evt_cnt=2; mode 11 repeat -> filt_level tracks, no toggle, evt_cnt stays 2.
REQ-033 All 4 channels mode 00 rise same cycle with cnt_clr high on pulse cycle -> evt_cnt=4; CNT_WIDTH=2 variant -> saturates at 3.
REQ-034 clr[0] held high on same cycle toggle[0] pulses -> sticky[0]=1; clr[0] next cycle -> sticky[0]=0, irq=0.
REQ-035 rst_n pulsed low mid-filter with level high, then released -> all outputs 0 during reset, single rising toggle 5 edges after release.
